// File: rtl/dict_mem_arbiter.sv
// Shares the single dictionary ROM between the CPU load path and the key-search engine.
// A {valid, port} tag pipeline steers every read's data back to the port that issued it.
module dict_mem_arbiter #(
   parameter int ROM_LATENCY  = 1,
   parameter int CPU_PRIORITY = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic [31:0] cpu_addr,
   output logic        cpu_gnt,
   output logic        cpu_rvalid,
   output logic [31:0] cpu_rdata,
   input  logic        eng_req,
   input  logic [31:0] eng_addr,
   output logic        eng_gnt,
   output logic        eng_rvalid,
   output logic [31:0] eng_rdata,
   output logic [31:0] address_dictmem,
   input  logic [31:0] q_dictmem,
   output logic [15:0] cpu_gnt_count,
   output logic [15:0] eng_gnt_count
);

   typedef enum logic { PORT_CPU = 1'b0, PORT_ENG = 1'b1 } port_e;

   typedef struct packed {
      logic  valid;
      port_e port;
   } tag_t;

   // One stage for the address register plus one per ROM latency cycle.
   localparam int DEPTH = ROM_LATENCY + 1;

   port_e       r_last_gnt;
   tag_t        r_tag [DEPTH];
   logic [31:0] r_addr;
   logic [15:0] r_cpu_cnt;
   logic [15:0] r_eng_cnt;

   logic        w_cpu_wins;
   logic        w_cpu_gnt;
   logic        w_eng_gnt;
   tag_t        w_new_tag;
   tag_t        w_tail;

   // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
   always_comb begin
      w_cpu_wins      = (CPU_PRIORITY != 0) || (r_last_gnt == PORT_ENG);
      w_cpu_gnt       = reset && cpu_req && (!eng_req || w_cpu_wins);
      w_eng_gnt       = reset && eng_req && !w_cpu_gnt;
      w_new_tag.valid = w_cpu_gnt || w_eng_gnt;
      w_new_tag.port  = w_eng_gnt ? PORT_ENG : PORT_CPU;
   end

   // NOTE: state uses non-blocking assignments so every stage shifts on the same edge.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_last_gnt <= PORT_ENG;
         r_addr     <= '0;
         r_cpu_cnt  <= '0;
         r_eng_cnt  <= '0;
         // NOTE: the tag array is reset because a stale valid bit would fire a phantom rvalid.
         for (int i = 0; i < DEPTH; i++) begin
            r_tag[i] <= '0;
         end
      end else begin
         r_tag[0] <= w_new_tag;
         for (int i = 1; i < DEPTH; i++) begin
            r_tag[i] <= r_tag[i-1];
         end
         if (w_cpu_gnt) begin
            r_last_gnt <= PORT_CPU;
            r_addr     <= cpu_addr;
         end else if (w_eng_gnt) begin
            r_last_gnt <= PORT_ENG;
            r_addr     <= eng_addr;
         end
         if (w_cpu_gnt && (r_cpu_cnt != 16'hFFFF)) begin
            r_cpu_cnt <= r_cpu_cnt + 16'd1;
         end
         if (w_eng_gnt && (r_eng_cnt != 16'hFFFF)) begin
            r_eng_cnt <= r_eng_cnt + 16'd1;
         end
      end
   end

   always_comb begin
      w_tail     = r_tag[DEPTH-1];
      cpu_rvalid = 1'b0;
      eng_rvalid = 1'b0;
      cpu_rdata  = '0;
      eng_rdata  = '0;
      if (reset && w_tail.valid) begin
         if (w_tail.port == PORT_ENG) begin
            eng_rvalid = 1'b1;
            eng_rdata  = q_dictmem;
         end else begin
            cpu_rvalid = 1'b1;
            cpu_rdata  = q_dictmem;
         end
      end
   end

   assign cpu_gnt         = w_cpu_gnt;
   assign eng_gnt         = w_eng_gnt;
   assign address_dictmem = r_addr;
   assign cpu_gnt_count   = r_cpu_cnt;
   assign eng_gnt_count   = r_eng_cnt;

endmodule

// File: tb/tb_dict_mem_arbiter.sv
// Bench for dict_mem_arbiter: three parameterisations, a latency-accurate ROM model and a
// queue-based reference model of grants, returns and counters built from the arbitration rules.
module tb_dict_mem_arbiter;

   localparam int N_DUT = 3;  // 0: lat 1 round-robin, 1: lat 1 CPU priority, 2: lat 3 round-robin

   typedef struct packed {
      logic        cgnt;
      logic        egnt;
      logic        crv;
      logic [31:0] crd;
      logic        erv;
      logic [31:0] erd;
      logic [31:0] addr;
      logic [15:0] ccnt;
      logic [15:0] ecnt;
   } snap_t;

   typedef struct {
      int          due;
      bit          eng;
      logic [31:0] addr;
   } rd_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        cpu_req         [N_DUT];
   logic [31:0] cpu_addr        [N_DUT];
   logic        cpu_gnt         [N_DUT];
   logic        cpu_rvalid      [N_DUT];
   logic [31:0] cpu_rdata       [N_DUT];
   logic        eng_req         [N_DUT];
   logic [31:0] eng_addr        [N_DUT];
   logic        eng_gnt         [N_DUT];
   logic        eng_rvalid      [N_DUT];
   logic [31:0] eng_rdata       [N_DUT];
   logic [31:0] address_dictmem [N_DUT];
   logic [31:0] q_dictmem       [N_DUT];
   logic [15:0] cpu_gnt_count   [N_DUT];
   logic [15:0] eng_gnt_count   [N_DUT];

   int    vectors     = 0;
   int    miscompares = 0;
   snap_t obs;
   snap_t want;

   int          m_lat;
   bit          m_prio;
   bit          m_last_eng;
   logic [15:0] m_cnt_c;
   logic [15:0] m_cnt_e;
   logic [31:0] m_addr;
   int          m_cyc = 0;
   rd_t         m_q [$];

   always #5 clock = ~clock;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      if (a == 32'h10) return 32'hDEADBEEF;
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   for (genvar g = 0; g < N_DUT; g++) begin : g_dut
      localparam int LAT = (g == 2) ? 3 : 1;
      logic [31:0] r_hist [LAT];

      dict_mem_arbiter #(
         .ROM_LATENCY (LAT),
         .CPU_PRIORITY((g == 1) ? 1 : 0)
      ) u_dut (
         .clock          (clock),
         .reset          (reset),
         .cpu_req        (cpu_req[g]),
         .cpu_addr       (cpu_addr[g]),
         .cpu_gnt        (cpu_gnt[g]),
         .cpu_rvalid     (cpu_rvalid[g]),
         .cpu_rdata      (cpu_rdata[g]),
         .eng_req        (eng_req[g]),
         .eng_addr       (eng_addr[g]),
         .eng_gnt        (eng_gnt[g]),
         .eng_rvalid     (eng_rvalid[g]),
         .eng_rdata      (eng_rdata[g]),
         .address_dictmem(address_dictmem[g]),
         .q_dictmem      (q_dictmem[g]),
         .cpu_gnt_count  (cpu_gnt_count[g]),
         .eng_gnt_count  (eng_gnt_count[g])
      );

      // ROM data is valid LAT cycles after the address it answers.
      always @(posedge clock) begin
         r_hist[0] <= address_dictmem[g];
         for (int i = 1; i < LAT; i++) r_hist[i] <= r_hist[i-1];
      end
      assign q_dictmem[g] = rom_word(r_hist[LAT-1]);
   end

   task automatic model_reset(input int k);
      m_lat      = (k == 2) ? 3 : 1;
      m_prio     = (k == 1);
      m_last_eng = 1'b1;
      m_cnt_c    = '0;
      m_cnt_e    = '0;
      m_addr     = '0;
      m_q.delete();
   endtask

   // Returns {eng_gnt, cpu_gnt} from the arbitration rules.
   function automatic logic [1:0] model_gnt(input logic c, input logic e);
      if (c && !e) return 2'b01;
      if (e && !c) return 2'b10;
      if (!c && !e) return 2'b00;
      if (m_prio || m_last_eng) return 2'b01;
      return 2'b10;
   endfunction

   // One clock cycle on instance k: drive, sample at negedge into obs, predict into want, advance.
   task automatic apply(input int k, input logic rst, input logic creq, input logic [31:0] caddr,
                        input logic ereq, input logic [31:0] eaddr);
      rd_t head;
      rd_t item;
      for (int i = 0; i < N_DUT; i++) begin
         cpu_req[i] = 1'b0; cpu_addr[i] = '0; eng_req[i] = 1'b0; eng_addr[i] = '0;
      end
      reset       = rst;
      cpu_req[k]  = creq;
      cpu_addr[k] = caddr;
      eng_req[k]  = ereq;
      eng_addr[k] = eaddr;
      @(negedge clock);
      obs.cgnt = cpu_gnt[k];
      obs.egnt = eng_gnt[k];
      obs.crv  = cpu_rvalid[k];
      obs.crd  = cpu_rdata[k];
      obs.erv  = eng_rvalid[k];
      obs.erd  = eng_rdata[k];
      obs.addr = address_dictmem[k];
      obs.ccnt = cpu_gnt_count[k];
      obs.ecnt = eng_gnt_count[k];
      want = '0;
      if (rst) {want.egnt, want.cgnt} = model_gnt(creq, ereq);
      want.addr = m_addr;
      want.ccnt = m_cnt_c;
      want.ecnt = m_cnt_e;
      if (m_q.size() > 0 && m_q[0].due == m_cyc) begin
         head = m_q.pop_front();
         if (rst && head.eng) begin
            want.erv = 1'b1;
            want.erd = rom_word(head.addr);
         end else if (rst) begin
            want.crv = 1'b1;
            want.crd = rom_word(head.addr);
         end
      end
      if (!rst) begin
         model_reset(k);
      end else if (want.cgnt || want.egnt) begin
         item.due  = m_cyc + 1 + m_lat;
         item.eng  = want.egnt;
         item.addr = want.egnt ? eaddr : caddr;
         m_q.push_back(item);
         m_addr     = item.addr;
         m_last_eng = want.egnt;
         if (want.cgnt && m_cnt_c != 16'hFFFF) m_cnt_c++;
         if (want.egnt && m_cnt_e != 16'hFFFF) m_cnt_e++;
      end
      m_cyc++;
      @(posedge clock);
      #1;
   endtask

   task automatic quiet_reset(input int k);
      model_reset(k);
      repeat (2) apply(k, 1'b0, 1'b0, '0, 1'b0, '0);
   endtask

   task automatic test_reset();
      quiet_reset(0);
      for (int i = 0; i < 3; i++) begin
         // Requests held during reset must not be granted.
         apply(0, i < 2 ? 1'b0 : 1'b1, i < 2, 32'h20, i < 2, 32'h24);
         vectors++;
         if (obs !== want) begin
            miscompares++;
            $display("FAIL reset cyc=%0d got=%h want=%h", m_cyc, obs, want);
         end
      end
   endtask

   task automatic test_single_cpu();
      quiet_reset(0);
      for (int i = 0; i < 5; i++) begin
         apply(0, 1'b1, i == 1, 32'h10, 1'b0, '0);
         vectors++;
         if (obs !== want) begin
            miscompares++;
            $display("FAIL single_cpu cyc=%0d got=%h want=%h", m_cyc, obs, want);
         end
         vectors++;
         if (i == 3 && (obs.crv !== 1'b1 || obs.crd !== 32'hDEADBEEF || obs.erv !== 1'b0)) begin
            miscompares++;
            $display("FAIL single_cpu_data rvalid=%b rdata=%h want 1/deadbeef", obs.crv, obs.crd);
         end
      end
   endtask

   task automatic test_round_robin();
      quiet_reset(0);
      for (int i = 0; i < 9; i++) begin
         apply(0, 1'b1, i < 6, 32'h100 + i, i < 6, 32'h200 + i);
         vectors++;
         if (obs !== want) begin
            miscompares++;
            $display("FAIL round_robin cyc=%0d got=%h want=%h", m_cyc, obs, want);
         end
         if (i < 6) begin
            vectors++;
            if (obs.cgnt !== (i % 2 == 0) || obs.egnt !== (i % 2 == 1)) begin
               miscompares++;
               $display("FAIL rr_order step=%0d cgnt=%b egnt=%b", i, obs.cgnt, obs.egnt);
            end
         end
      end
      vectors++;
      if (obs.ccnt !== 16'd3 || obs.ecnt !== 16'd3) begin
         miscompares++;
         $display("FAIL rr_counts got=%0d/%0d want 3/3", obs.ccnt, obs.ecnt);
      end
   endtask

   task automatic test_priority();
      quiet_reset(1);
      for (int i = 0; i < 9; i++) begin
         apply(1, 1'b1, i < 4, 32'h300 + i, i < 6, 32'h400);
         vectors++;
         if (obs !== want) begin
            miscompares++;
            $display("FAIL priority cyc=%0d got=%h want=%h", m_cyc, obs, want);
         end
         if (i < 6) begin
            vectors++;
            if (obs.egnt !== (i >= 4) || (i < 5 && obs.ecnt !== 16'd0)) begin
               miscompares++;
               $display("FAIL prio_eng step=%0d egnt=%b ecnt=%0d", i, obs.egnt, obs.ecnt);
            end
         end
      end
   endtask

   task automatic test_latency3();
      quiet_reset(2);
      for (int i = 0; i < 9; i++) begin
         apply(2, 1'b1, 1'b0, '0, i < 3, 32'hA0 + i);
         vectors++;
         if (obs !== want) begin
            miscompares++;
            $display("FAIL latency3 cyc=%0d got=%h want=%h", m_cyc, obs, want);
         end
         vectors++;
         if (obs.erv !== (i >= 4 && i <= 6)) begin
            miscompares++;
            $display("FAIL lat3_rvalid step=%0d got=%b want=%b", i, obs.erv, (i >= 4 && i <= 6));
         end
      end
   endtask

   task automatic test_back_to_back(input int k);
      logic [31:0] ca;
      logic [31:0] ea;
      quiet_reset(k);
      ca = $urandom;
      ea = $urandom;
      for (int i = 0; i < 16; i++) begin
         apply(k, 1'b1, i < 12, ca, i < 12, ea);
         vectors++;
         if (obs !== want) begin
            miscompares++;
            $display("FAIL back_to_back inst=%0d cyc=%0d got=%h want=%h", k, m_cyc, obs, want);
         end
         if (want.cgnt) ca = $urandom;
         if (want.egnt) ea = $urandom;
      end
   endtask

   task automatic test_reset_midflight();
      quiet_reset(0);
      apply(0, 1'b1, 1'b0, '0, 1'b0, '0);
      for (int i = 0; i < 5; i++) begin
         apply(0, i != 1, i == 0, 32'h44, 1'b0, '0);
         vectors++;
         if (obs !== want) begin
            miscompares++;
            $display("FAIL reset_midflight cyc=%0d got=%h want=%h", m_cyc, obs, want);
         end
         vectors++;
         if (i >= 2 && (obs.crv !== 1'b0 || obs.addr !== 32'd0 || obs.ccnt !== 16'd0 || obs.ecnt !== 16'd0)) begin
            miscompares++;
            $display("FAIL midflight_state step=%0d rvalid=%b addr=%h counts=%0d/%0d want 0",
                     i, obs.crv, obs.addr, obs.ccnt, obs.ecnt);
         end
      end
   endtask

   task automatic test_random(input int k, input int n);
      logic        cp;
      logic        ep;
      logic        rst;
      logic [31:0] ca;
      logic [31:0] ea;
      quiet_reset(k);
      cp = 1'b0;
      ep = 1'b0;
      ca = '0;
      ea = '0;
      for (int i = 0; i < n; i++) begin
         if (!cp && $urandom_range(0, 3) != 0) begin cp = 1'b1; ca = $urandom; end
         if (!ep && $urandom_range(0, 3) != 0) begin ep = 1'b1; ea = $urandom; end
         rst = ($urandom_range(0, 63) != 0);
         apply(k, rst, cp, ca, ep, ea);
         vectors++;
         if (obs !== want) begin
            miscompares++;
            $display("FAIL random inst=%0d cyc=%0d got=%h want=%h", k, m_cyc, obs, want);
         end
         if (want.cgnt || !rst) cp = 1'b0;
         if (want.egnt || !rst) ep = 1'b0;
      end
   endtask

   task automatic test_saturation();
      quiet_reset(0);
      for (int i = 0; i < 65534; i++) apply(0, 1'b1, 1'b0, '0, 1'b1, i);
      for (int i = 0; i < 5; i++) begin
         apply(0, 1'b1, 1'b0, '0, i < 3, 32'h5000 + i);
         vectors++;
         if (obs !== want) begin
            miscompares++;
            $display("FAIL saturation cyc=%0d got=%h want=%h", m_cyc, obs, want);
         end
      end
      vectors++;
      if (obs.ecnt !== 16'hFFFF || obs.ccnt !== 16'd0) begin
         miscompares++;
         $display("FAIL sat_counts eng=%h cpu=%h want ffff/0000", obs.ecnt, obs.ccnt);
      end
   endtask

   initial begin
      reset = 1'b0;
      for (int i = 0; i < N_DUT; i++) begin
         cpu_req[i] = 1'b0; cpu_addr[i] = '0; eng_req[i] = 1'b0; eng_addr[i] = '0;
      end
      @(posedge clock);
      #1;
      test_reset();
      test_single_cpu();
      test_round_robin();
      test_priority();
      test_latency3();
      test_back_to_back(0);
      test_back_to_back(2);
      test_reset_midflight();
      test_random(0, 300);
      test_random(1, 300);
      test_random(2, 300);
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
